// File: rtl/rf_report_uart_tx_if.sv
// Report stream handshake from the RF control top: one-cycle send_en strobe with a 64-bit word.
interface rf_report_uart_tx_if;
  logic        send_en;
  logic [63:0] send_data;

  modport master (output send_en, output send_data);
  modport slave  (input  send_en, input  send_data);
endinterface

// File: rtl/rf_report_uart_tx.sv
// Buffers 64-bit RF status reports in a small FIFO and ships each one MSB byte first as 8N1 UART.
// Optional REPORT_CHKSUM_EN appends a ninth byte holding the XOR of the eight data bytes.
module rf_report_uart_tx #(
  parameter int BAUD_DIV = 174,
  parameter int FIFO_AW  = 3
) (
  input  logic                 clk_20mhz,
  input  logic                 sys_rest,
  rf_report_uart_tx_if.slave   rpt,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 fifo_full,
  output logic [15:0]          drop_cnt,
  output logic                 frame_done
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CW-1:0]      CNT_LOAD  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]      CNT_ONE   = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   LVL_ONE   = 1;
  localparam logic [FIFO_AW:0]   LVL_DEPTH = (FIFO_AW+1)'(DEPTH);
`ifdef REPORT_CHKSUM_EN
  localparam logic [3:0]         LAST_BYTE = 4'd8;
`else
  localparam logic [3:0]         LAST_BYTE = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [63:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [63:0]         shreg;
  logic [7:0]          bits;
  logic [2:0]          bit_idx;
  logic [3:0]          byte_idx;
  logic [CW-1:0]       cnt;
  logic [7:0]          cur_byte;
  logic                push;
  logic                pop;
`ifdef REPORT_CHKSUM_EN
  logic [7:0]          chk;
`endif

  assign fifo_full = (fifo_level == LVL_DEPTH);
  assign push      = rpt.send_en && !fifo_full;
  assign pop       = (state == IDLE) && (fifo_level != '0);

  always_comb begin
    cur_byte = shreg[63:56];
`ifdef REPORT_CHKSUM_EN
    if (byte_idx == LAST_BYTE) cur_byte = chk;
`endif
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_20mhz) begin
    if (push) mem[wr_ptr] <= rpt.send_data;
  end

  always_ff @(posedge clk_20mhz or posedge sys_rest) begin
    if (sys_rest) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (rpt.send_en && fifo_full && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_20mhz or posedge sys_rest) begin
    if (sys_rest) begin
      state      <= IDLE;
      uart_txd   <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bits       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      cnt        <= '0;
`ifdef REPORT_CHKSUM_EN
      chk        <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            cnt      <= CNT_LOAD;
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef REPORT_CHKSUM_EN
            chk      <= '0;
`endif
            state    <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt      <= CNT_LOAD;
            uart_txd <= cur_byte[0];
            bits     <= {1'b0, cur_byte[7:1]};
            bit_idx  <= '0;
`ifdef REPORT_CHKSUM_EN
            chk      <= chk ^ cur_byte;
`endif
            state    <= DATA;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_LOAD;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              uart_txd <= bits[0];
              bits     <= bits >> 1;
              bit_idx  <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (byte_idx == LAST_BYTE) begin
              frame_done <= 1'b1;
              tx_busy    <= 1'b0;
              state      <= IDLE;
            end else begin
              // Next byte starts straight away: no idle gap inside a frame.
              byte_idx <= byte_idx + 4'd1;
              shreg    <= {shreg[55:0], 8'h00};
              cnt      <= CNT_LOAD;
              uart_txd <= 1'b0;
              state    <= START;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_report_uart_tx.sv
// Bench for rf_report_uart_tx: a queue-based reference of the report path checked every cycle,
// plus scenario tasks that decode frames from the line and check latency, overflow and reset.
module tb_rf_report_uart_tx;
  localparam int B     = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef REPORT_CHKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FLEN = NB * 10 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_report_uart_tx_if rpt();
  logic        uart_txd;
  logic        tx_busy;
  logic [AW:0] fifo_level;
  logic        fifo_full;
  logic [15:0] drop_cnt;
  logic        frame_done;

  rf_report_uart_tx #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
    .clk_20mhz (clk),
    .sys_rest  (rst),
    .rpt       (rpt.slave),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .fifo_level(fifo_level),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference: queue of accepted words, remaining cycles of the frame on the wire, drop tally.
  logic [63:0] mq[$];
  logic [63:0] m_cur = '0;
  int          m_rem = 0;
  int          m_t = 0;
  int          m_drops = 0;
  bit          m_fd = 1'b0;
  bit          m_full;
  bit          mon_en = 1'b0;

  function automatic logic exp_line(input logic [63:0] w, input int t);
    int k;
    int p;
    logic [7:0] b;
    k = t / (10 * B);
    p = (t / B) % 10;
    if (k < 8) b = w[63-8*k -: 8];
    else begin
      b = '0;
      for (int i = 0; i < 8; i++) b ^= w[8*i +: 8];
    end
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_full = (mq.size() == DEPTH);
      m_fd   = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        m_t++;
        if (m_rem == 0) m_fd = 1'b1;
      end else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_rem = FLEN;
        m_t   = 0;
      end
      if (rpt.send_en) begin
        if (!m_full) mq.push_back(rpt.send_data);
        else if (m_drops < 65535) m_drops++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      logic exp_txd;
      exp_txd = (m_rem > 0) ? exp_line(m_cur, m_t) : 1'b1;
      checks++;
      if (uart_txd !== exp_txd) begin
        errors++; $display("FAIL mon_txd t=%0t got %b exp %b", $time, uart_txd, exp_txd);
      end
      checks++;
      if (tx_busy !== (m_rem > 0)) begin
        errors++; $display("FAIL mon_busy t=%0t got %b exp %b", $time, tx_busy, (m_rem > 0));
      end
      checks++;
      if (fifo_level !== (AW+1)'(mq.size())) begin
        errors++; $display("FAIL mon_level t=%0t got %0d exp %0d", $time, fifo_level, mq.size());
      end
      checks++;
      if (fifo_full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL mon_full t=%0t got %b exp %b", $time, fifo_full, (mq.size() == DEPTH));
      end
      checks++;
      if (drop_cnt !== 16'(m_drops)) begin
        errors++; $display("FAIL mon_drop t=%0t got %0d exp %0d", $time, drop_cnt, m_drops);
      end
      checks++;
      if (frame_done !== m_fd) begin
        errors++; $display("FAIL mon_frame_done t=%0t got %b exp %b", $time, frame_done, m_fd);
      end
    end
  end

  // Waits for the start bit, samples every bit at its centre, then measures cycles to frame_done.
  task automatic capture_frame(output logic [63:0] w, output logic [7:0] ck,
                               output int wait_cyc, output int len);
    bit samp[FLEN];
    logic [7:0] b;
    w = '0; ck = '0; wait_cyc = 0; len = -1;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (uart_txd !== 1'b0 && wait_cyc < 2000);
    if (uart_txd !== 1'b0) return;
    for (int j = 0; j < FLEN; j++) begin
      samp[j] = uart_txd;
      @(negedge clk);
    end
    len = FLEN;
    while (frame_done !== 1'b1 && len < FLEN + 50) begin
      @(negedge clk);
      len++;
    end
    for (int k = 0; k < NB; k++) begin
      for (int i = 0; i < 8; i++) b[i] = samp[k*10*B + (i+1)*B + B/2];
      if (k < 8) w[63-8*k -: 8] = b;
      else ck = b;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b exp 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", tx_busy); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", fifo_full); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_frames();
    logic [63:0] words[4];
    logic [63:0] got;
    logic [7:0]  ck;
    int wc;
    int len;
    words[0] = 64'hBBBB_BBBB_0000_0002;
    words[1] = 64'h0102_0304_0506_0708;
    words[2] = {$urandom, $urandom};
    words[3] = {$urandom, $urandom};
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      rpt.send_en = 1'b1; rpt.send_data = words[n];
      @(negedge clk);
      rpt.send_en = 1'b0;
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL frame%0d_early_txd got %b exp 1", n, uart_txd); end
      capture_frame(got, ck, wc, len);
      checks++;
      if (wc !== 1) begin errors++; $display("FAIL frame%0d_latency got %0d exp 1", n, wc); end
      checks++;
      if (len !== FLEN) begin errors++; $display("FAIL frame%0d_length got %0d exp %0d", n, len, FLEN); end
      checks++;
      if (got !== words[n]) begin errors++; $display("FAIL frame%0d_word got %h exp %h", n, got, words[n]); end
`ifdef REPORT_CHKSUM_EN
      begin
        logic [7:0] xr;
        xr = '0;
        for (int i = 0; i < 8; i++) xr ^= words[n][8*i +: 8];
        checks++;
        if (ck !== xr) begin errors++; $display("FAIL frame%0d_chksum got %h exp %h", n, ck, xr); end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    int fd_cnt;
    int c;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      w = {$urandom, $urandom};
      w[63:60] = 4'(i);
      rpt.send_en = 1'b1; rpt.send_data = w;
      @(negedge clk);
    end
    rpt.send_en = 1'b0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL burst_level got %0d exp 8", fifo_level); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL burst_full got %b exp 1", fifo_full); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL burst_drop got %0d exp 1", drop_cnt); end
    fd_cnt = 0;
    c = 0;
    while (fd_cnt < 9 && c < 10*FLEN) begin
      @(negedge clk);
      c++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++; if (fd_cnt !== 9) begin errors++; $display("FAIL burst_frames got %0d exp 9", fd_cnt); end
    checks++; if (c !== 9*FLEN) begin errors++; $display("FAIL burst_span got %0d exp %0d", c, 9*FLEN); end
    @(negedge clk);
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL burst_drained got %0d exp 0", fifo_level); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] got;
    logic [7:0]  ck;
    int wc;
    int len;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rpt.send_en = 1'b1; rpt.send_data = {$urandom, $urandom};
      @(negedge clk);
    end
    rpt.send_en = 1'b0;
    repeat (128) @(negedge clk);
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL mid_queued got %0d exp 3", fifo_level); end
    #2;
    rst = 1'b1;
    mq.delete(); m_rem = 0; m_t = 0; m_drops = 0; m_fd = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b exp 1", uart_txd); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", fifo_level); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_drop got %0d exp 0", drop_cnt); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rpt.send_en = 1'b1; rpt.send_data = 64'hCBBC_0000_0000_0001;
    @(negedge clk);
    rpt.send_en = 1'b0;
    capture_frame(got, ck, wc, len);
    checks++; if (got !== 64'hCBBC_0000_0000_0001) begin errors++; $display("FAIL mid_new_word got %h exp cbbc000000000001", got); end
    checks++; if (len !== FLEN) begin errors++; $display("FAIL mid_new_length got %0d exp %0d", len, FLEN); end
    repeat (2*FLEN) @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_no_stale got busy %b exp 0", tx_busy); end
  endtask

  task automatic test_drop_saturate();
    int c;
    @(negedge clk);
    rpt.send_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      rpt.send_data = {$urandom, $urandom};
      @(negedge clk);
    end
    rpt.send_en = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_drop got %h exp ffff", drop_cnt); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL sat_full got %b exp 1", fifo_full); end
    c = 0;
    while ((fifo_level !== '0 || tx_busy !== 1'b0) && c < 12*FLEN) begin
      @(negedge clk);
      c++;
    end
    checks++; if (fifo_level !== '0 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL sat_drain got level %0d busy %b exp 0 0", fifo_level, tx_busy);
    end
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", drop_cnt); end
  endtask

  initial begin
    rpt.send_en = 1'b0;
    rpt.send_data = '0;
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_drop_saturate();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
